// File: rtl/csr_access_arbiter.sv
// Two-requester (hart / debug) arbiter for the single CSR file port; each access runs IDLE->RD->WB, grant to next grant is 3 cycles.
// Requests are level-held until the grant; a stalled clk_en_i freezes the sequence in place.
module csr_access_arbiter #(
  parameter int XLEN             = 32,
  parameter int DBG_STARVE_LIMIT = 8
) (
  input  logic            clk_i,
  input  logic            resetb_i,
  input  logic            clk_en_i,
  input  logic            hart_req_i,
  input  logic [11:0]     hart_addr_i,
  input  logic [1:0]      hart_mode_i,
  input  logic [XLEN-1:0] hart_wdata_i,
  input  logic            hart_flush_i,
  output logic            hart_gnt_o,
  output logic            hart_done_o,
  output logic [XLEN-1:0] hart_rdata_o,
  output logic            hart_ilgl_o,
  input  logic            dbg_req_i,
  input  logic            dbg_wr_i,
  input  logic [11:0]     dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_gnt_o,
  output logic            dbg_done_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            dbg_err_o,
  output logic            csr_exs_en_o,
  output logic            csr_rd_o,
  output logic [11:0]     csr_rd_addr_o,
  input  logic [XLEN-1:0] csr_rd_data_i,
  input  logic            csr_illegal_rd_i,
  input  logic            csr_illegal_wr_i,
  output logic            csr_wr_o,
  output logic [1:0]      csr_wr_mode_o,
  output logic [11:0]     csr_wr_addr_o,
  output logic [XLEN-1:0] csr_wr_data_o
);

  localparam int CW = $clog2(DBG_STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, RD, WB} state_t;

  typedef struct packed {
    logic            dbg;
    logic [1:0]      mode;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic          ilgl_q, ilgl_d;
  logic [CW-1:0] starve_q, starve_d;

  logic can_grant, starved, hart_win, dbg_win;
  logic in_rd, in_wb, acc_wr, hart_kill;

  assign can_grant = (state_q == IDLE) & clk_en_i & resetb_i;
  assign starved   = dbg_req_i & (starve_q == CW'(DBG_STARVE_LIMIT));
  assign hart_win  = can_grant & hart_req_i & ~hart_flush_i & ~starved;
  assign dbg_win   = can_grant & dbg_req_i & ~hart_win;

  assign in_rd     = (state_q == RD);
  assign in_wb     = (state_q == WB);
  assign acc_wr    = (req_q.mode != 2'b00);
  assign hart_kill = ~req_q.dbg & hart_flush_i;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    ilgl_d   = ilgl_q;
    starve_d = starve_q;
    if (!dbg_req_i || dbg_win) begin
      starve_d = '0;
    end else if (hart_win && starve_q != CW'(DBG_STARVE_LIMIT)) begin
      starve_d = starve_q + CW'(1);
    end
    case (state_q)
      IDLE: begin
        if (hart_win) begin
          req_d   = '{dbg: 1'b0, mode: hart_mode_i, addr: hart_addr_i, wdata: hart_wdata_i};
          state_d = RD;
        end else if (dbg_win) begin
          req_d   = '{dbg: 1'b1, mode: {1'b0, dbg_wr_i}, addr: dbg_addr_i, wdata: dbg_wdata_i};
          state_d = RD;
        end
      end
      RD: begin
        // Writes must also be readable: set/clear need the old value.
        ilgl_d  = csr_illegal_rd_i | (acc_wr & csr_illegal_wr_i);
        state_d = hart_kill ? IDLE : WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      ilgl_q   <= 1'b0;
      starve_q <= '0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      req_q    <= req_d;
      ilgl_q   <= ilgl_d;
      starve_q <= starve_d;
    end
  end

  assign hart_gnt_o    = hart_win;
  assign dbg_gnt_o     = dbg_win;
  assign hart_done_o   = in_wb & ~req_q.dbg & ~hart_flush_i;
  assign dbg_done_o    = in_wb & req_q.dbg;
  assign hart_rdata_o  = {XLEN{hart_done_o}} & csr_rd_data_i;
  assign dbg_rdata_o   = {XLEN{dbg_done_o}} & csr_rd_data_i;
  assign hart_ilgl_o   = hart_done_o & ilgl_q;
  assign dbg_err_o     = dbg_done_o & ilgl_q;

  assign csr_exs_en_o  = (state_q != IDLE);
  assign csr_rd_o      = in_rd;
  assign csr_rd_addr_o = req_q.addr;
  assign csr_wr_o      = in_wb & acc_wr & ~ilgl_q & ~hart_kill;
  assign csr_wr_mode_o = req_q.mode;
  assign csr_wr_addr_o = req_q.addr;
  assign csr_wr_data_o = req_q.wdata;

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a starvation limit of 2.
module tb_csr_access_arbiter;

  logic        clk_i = 1'b0;
  logic        resetb_i = 1'b0;
  logic        clk_en_i = 1'b1;
  logic        hart_req_i = 1'b0;
  logic [11:0] hart_addr_i = '0;
  logic [1:0]  hart_mode_i = '0;
  logic [31:0] hart_wdata_i = '0;
  logic        hart_flush_i = 1'b0;
  logic        hart_gnt_o, hart_done_o, hart_ilgl_o;
  logic [31:0] hart_rdata_o;
  logic        dbg_req_i = 1'b0;
  logic        dbg_wr_i = 1'b0;
  logic [11:0] dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic        dbg_gnt_o, dbg_done_o, dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic        csr_exs_en_o, csr_rd_o, csr_wr_o;
  logic [11:0] csr_rd_addr_o, csr_wr_addr_o;
  logic [31:0] csr_rd_data_i = '0;
  logic        csr_illegal_rd_i = 1'b0;
  logic        csr_illegal_wr_i = 1'b0;
  logic [1:0]  csr_wr_mode_o;
  logic [31:0] csr_wr_data_o;

  int checks = 0;
  int failures = 0;

  csr_access_arbiter #(.XLEN(32), .DBG_STARVE_LIMIT(2)) dut (
    .clk_i(clk_i), .resetb_i(resetb_i), .clk_en_i(clk_en_i),
    .hart_req_i(hart_req_i), .hart_addr_i(hart_addr_i), .hart_mode_i(hart_mode_i),
    .hart_wdata_i(hart_wdata_i), .hart_flush_i(hart_flush_i),
    .hart_gnt_o(hart_gnt_o), .hart_done_o(hart_done_o),
    .hart_rdata_o(hart_rdata_o), .hart_ilgl_o(hart_ilgl_o),
    .dbg_req_i(dbg_req_i), .dbg_wr_i(dbg_wr_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_done_o(dbg_done_o),
    .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
    .csr_exs_en_o(csr_exs_en_o), .csr_rd_o(csr_rd_o), .csr_rd_addr_o(csr_rd_addr_o),
    .csr_rd_data_i(csr_rd_data_i), .csr_illegal_rd_i(csr_illegal_rd_i),
    .csr_illegal_wr_i(csr_illegal_wr_i), .csr_wr_o(csr_wr_o),
    .csr_wr_mode_o(csr_wr_mode_o), .csr_wr_addr_o(csr_wr_addr_o),
    .csr_wr_data_o(csr_wr_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, {24'd0, hart_gnt_o, hart_done_o, hart_ilgl_o, dbg_gnt_o,
                        dbg_done_o, dbg_err_o, csr_exs_en_o, csr_rd_o}, 32'd0);
    chk({tag, ".wr"}, {31'd0, csr_wr_o}, 32'd0);
    chk({tag, ".rdaddr"}, {20'd0, csr_rd_addr_o}, 32'd0);
    chk({tag, ".hrdata"}, hart_rdata_o, 32'd0);
    chk({tag, ".drdata"}, dbg_rdata_o, 32'd0);
    chk({tag, ".wrbus"}, {18'd0, csr_wr_mode_o, csr_wr_addr_o} | csr_wr_data_o, 32'd0);
  endtask

  logic [5:0] dbg_order;

  initial begin
    // Reset: outputs idle even with a request pending
    #2;
    hart_req_i = 1'b1;
    #1;
    chk_all_zero("reset");
    hart_req_i = 1'b0;
    #9 resetb_i = 1'b1;

    // Hart read of 0x340
    tick();
    hart_req_i = 1'b1; hart_mode_i = 2'b00; hart_addr_i = 12'h340;
    #1;
    chk("rd.gnt", {31'd0, hart_gnt_o}, 32'd1);
    chk("rd.rd_c0", {31'd0, csr_rd_o}, 32'd0);
    tick();
    hart_req_i = 1'b0;
    #1;
    chk("rd.rd_c1", {30'd0, csr_exs_en_o, csr_rd_o}, 32'd3);
    chk("rd.addr", {20'd0, csr_rd_addr_o}, 32'h340);
    chk("rd.gnt_c1", {31'd0, hart_gnt_o}, 32'd0);
    tick();
    csr_rd_data_i = 32'hDEADBEEF;
    #1;
    chk("rd.done", {31'd0, hart_done_o}, 32'd1);
    chk("rd.rdata", hart_rdata_o, 32'hDEADBEEF);
    chk("rd.nowr", {30'd0, csr_wr_o, hart_ilgl_o}, 32'd0);
    tick();
    csr_rd_data_i = 32'h0;
    #1;
    chk("rd.idle", {29'd0, csr_exs_en_o, csr_rd_o, hart_done_o}, 32'd0);

    // Hart set on 0x300
    hart_req_i = 1'b1; hart_mode_i = 2'b10; hart_addr_i = 12'h300; hart_wdata_i = 32'h8;
    #1;
    chk("set.gnt", {31'd0, hart_gnt_o}, 32'd1);
    tick();
    hart_req_i = 1'b0;
    tick();
    csr_rd_data_i = 32'h0;
    #1;
    chk("set.wr", {31'd0, csr_wr_o}, 32'd1);
    chk("set.mode", {30'd0, csr_wr_mode_o}, 32'd2);
    chk("set.waddr", {20'd0, csr_wr_addr_o}, 32'h300);
    chk("set.wdata", csr_wr_data_o, 32'h8);
    chk("set.raddr", {20'd0, csr_rd_addr_o}, 32'h300);
    chk("set.done", {31'd0, hart_done_o}, 32'd1);
    chk("set.rdata", hart_rdata_o, 32'h0);

    // Illegal write to 0xF11
    tick();
    hart_req_i = 1'b1; hart_mode_i = 2'b01; hart_addr_i = 12'hF11; hart_wdata_i = 32'h5;
    #1;
    chk("ilg.gnt", {31'd0, hart_gnt_o}, 32'd1);
    tick();
    hart_req_i = 1'b0; csr_illegal_wr_i = 1'b1;
    tick();
    csr_illegal_wr_i = 1'b0; csr_rd_data_i = 32'h11;
    #1;
    chk("ilg.nowr", {31'd0, csr_wr_o}, 32'd0);
    chk("ilg.done", {30'd0, hart_done_o, hart_ilgl_o}, 32'd3);
    chk("ilg.rdata", hart_rdata_o, 32'h11);

    // Starvation with limit 2: hart, hart, dbg, hart, hart, dbg
    dbg_order = 6'b100100;
    tick();
    hart_req_i = 1'b1; hart_mode_i = 2'b00; hart_addr_i = 12'h341;
    dbg_req_i = 1'b1; dbg_wr_i = 1'b0; dbg_addr_i = 12'h7B0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      #1;
      chk($sformatf("starve.g%0d", i), {30'd0, hart_gnt_o, dbg_gnt_o},
          dbg_order[i] ? 32'd1 : 32'd2);
      tick();
      if (i == 5) begin
        hart_req_i = 1'b0; dbg_req_i = 1'b0;
      end
      tick();
    end

    // Flush in IDLE blocks the grant, flush in RD kills the access
    tick();
    hart_req_i = 1'b1; hart_mode_i = 2'b01; hart_addr_i = 12'h305; hart_wdata_i = 32'hAA;
    hart_flush_i = 1'b1;
    #1;
    chk("fli.blk", {31'd0, hart_gnt_o}, 32'd0);
    hart_flush_i = 1'b0;
    #1;
    chk("fli.gnt", {31'd0, hart_gnt_o}, 32'd1);
    tick();
    hart_req_i = 1'b0; hart_flush_i = 1'b1;
    #1;
    chk("flr.rd", {31'd0, csr_rd_o}, 32'd1);
    tick();
    #1;
    chk("flr.idle", {29'd0, csr_exs_en_o, csr_wr_o, hart_done_o}, 32'd0);
    hart_flush_i = 1'b0;

    // Flush in WB of a hart write, then a debug write is unaffected by flush
    hart_req_i = 1'b1;
    #1;
    chk("flw.gnt", {31'd0, hart_gnt_o}, 32'd1);
    tick();
    hart_req_i = 1'b0;
    tick();
    hart_flush_i = 1'b1;
    #1;
    chk("flw.nowr", {30'd0, csr_wr_o, hart_done_o}, 32'd0);
    tick();
    hart_flush_i = 1'b0;
    #1;
    chk("flw.idle", {31'd0, csr_exs_en_o}, 32'd0);
    dbg_req_i = 1'b1; dbg_wr_i = 1'b1; dbg_addr_i = 12'h340; dbg_wdata_i = 32'h1234;
    #1;
    chk("dw.gnt", {30'd0, dbg_gnt_o, hart_gnt_o}, 32'd2);
    tick();
    dbg_req_i = 1'b0;
    #1;
    chk("dw.rdaddr", {20'd0, csr_rd_addr_o}, 32'h340);
    tick();
    hart_flush_i = 1'b1; csr_rd_data_i = 32'h77;
    #1;
    chk("dw.wr", {31'd0, csr_wr_o}, 32'd1);
    chk("dw.mode", {30'd0, csr_wr_mode_o}, 32'd1);
    chk("dw.waddr", {20'd0, csr_wr_addr_o}, 32'h340);
    chk("dw.wdata", csr_wr_data_o, 32'h1234);
    chk("dw.done", {29'd0, dbg_done_o, dbg_err_o, hart_done_o}, 32'd4);
    chk("dw.rdata", dbg_rdata_o, 32'h77);
    tick();
    hart_flush_i = 1'b0;

    // Async reset in the middle of RD
    hart_req_i = 1'b1; hart_mode_i = 2'b01; hart_addr_i = 12'h300; hart_wdata_i = 32'h3;
    #1;
    chk("rst.gnt", {31'd0, hart_gnt_o}, 32'd1);
    tick();
    hart_req_i = 1'b0;
    #1;
    chk("rst.rd", {31'd0, csr_rd_o}, 32'd1);
    #1 resetb_i = 1'b0;
    #1;
    chk_all_zero("rstmid");
    #1 resetb_i = 1'b1;
    tick();
    #1;
    chk("rst.nowb", {30'd0, csr_exs_en_o, csr_wr_o}, 32'd0);

    // Debug read with clk_en_i low for 3 cycles while in RD
    dbg_req_i = 1'b1; dbg_wr_i = 1'b0; dbg_addr_i = 12'h7B0;
    #1;
    chk("ce.gnt", {31'd0, dbg_gnt_o}, 32'd1);
    tick();
    dbg_req_i = 1'b0; clk_en_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) tick();
      #1;
      chk($sformatf("ce.hold%0d", c), {29'd0, csr_exs_en_o, csr_rd_o, dbg_done_o}, 32'd6);
    end
    tick();
    clk_en_i = 1'b1;
    #1;
    chk("ce.en1", {29'd0, csr_exs_en_o, csr_rd_o, dbg_done_o}, 32'd6);
    tick();
    csr_rd_data_i = 32'hCAFE;
    #1;
    chk("ce.done", {30'd0, dbg_done_o, csr_wr_o}, 32'd2);
    chk("ce.rdata", dbg_rdata_o, 32'hCAFE);
    tick();
    #1;
    chk("ce.idle", {30'd0, csr_exs_en_o, dbg_done_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
